// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register with hold / bubble / flush control and masked NOP insertion.
// Optional statistics counters (stall/bubble/flush) are built when PIPE_STAT_EN is defined.
module pipe_stage_reg #(
  parameter int                CTRL_W    = 16,
  parameter int                DATA_W    = 160,
  parameter logic [CTRL_W-1:0] KILL_MASK = {CTRL_W{1'b1}},
  parameter int                CNT_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              bubble,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAT_EN
  ,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_LOAD
  } action_t;

  action_t           act;
  logic              kill;
  logic              valid_reg, valid_next;
  logic [CTRL_W-1:0] ctrl_reg, ctrl_next, ctrl_src;
  logic [DATA_W-1:0] data_reg, data_next;

  // Single winning action per edge, resolved in fixed priority order.
  always_comb begin
    act = ACT_LOAD;
    if (reset)       act = ACT_RESET;
    else if (flush)  act = ACT_FLUSH;
    else if (hold)   act = ACT_HOLD;
    else if (bubble) act = ACT_BUBBLE;
  end

  // A NOP enters on flush, bubble, or a load of an empty upstream slot.
  assign kill     = (act == ACT_FLUSH) || (act == ACT_BUBBLE) ||
                    ((act == ACT_LOAD) && !in_valid);
  assign ctrl_src = (act == ACT_LOAD) ? in_ctrl : ctrl_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_bit
      assign ctrl_next[gi] = (kill && KILL_MASK[gi]) ? 1'b0 : ctrl_src[gi];
    end
  endgenerate

  always_comb begin
    valid_next = valid_reg;
    data_next  = data_reg;
    case (act)
      ACT_FLUSH, ACT_BUBBLE: valid_next = 1'b0;
      ACT_LOAD: begin
        valid_next = in_valid;
        data_next  = in_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
      data_reg  <= '0;
    end else begin
      valid_reg <= valid_next;
      ctrl_reg  <= ctrl_next;
      data_reg  <= data_next;
    end
  end

  assign out_valid = valid_reg;
  assign out_ctrl  = ctrl_reg;
  assign out_data  = data_reg;

`ifdef PIPE_STAT_EN
  // Index 0: stall, 1: bubble, 2: flush. Counters stick at all-ones.
  logic [2:0]       evt;
  logic [CNT_W-1:0] cnt_reg [3];

  assign evt = {act == ACT_FLUSH, act == ACT_BUBBLE, act == ACT_HOLD};

  generate
    for (gi = 0; gi < 3; gi++) begin : g_stat_cnt
      always_ff @(posedge clk) begin
        if (reset || stat_clr)
          cnt_reg[gi] <= '0;
        else if (evt[gi] && (cnt_reg[gi] != {CNT_W{1'b1}}))
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
      end
    end
  endgenerate

  assign stall_cnt  = cnt_reg[0];
  assign bubble_cnt = cnt_reg[1];
  assign flush_cnt  = cnt_reg[2];
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios with literal expectations,
// then randomized control traffic checked every cycle against a behavioural model.
module tb_pipe_stage_reg;
  localparam int         CW    = 8;
  localparam int         DW    = 32;
  localparam logic [7:0] KMASK = 8'h0F;
  localparam int         CNTW  = 2;
  localparam int         CMAX  = (1 << CNTW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1, hold = 1'b0, bubble = 1'b0, flush = 1'b0;
  logic          in_valid = 1'b0, stat_clr = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [CNTW-1:0] stall_cnt, bubble_cnt, flush_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model of the stage contents and the event counters.
  logic          m_valid;
  logic [CW-1:0] m_ctrl;
  logic [DW-1:0] m_data;
  int            m_stall = 0, m_bubble = 0, m_flush = 0;

  pipe_stage_reg #(
    .CTRL_W(CW), .DATA_W(DW), .KILL_MASK(KMASK), .CNT_W(CNTW)
  ) dut (
    .clk(clk), .reset(reset), .hold(hold), .bubble(bubble), .flush(flush),
    .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ctrl(out_ctrl), .out_data(out_data)
`ifdef PIPE_STAT_EN
    , .stat_clr(stat_clr), .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

`ifndef PIPE_STAT_EN
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b0; m_ctrl = '0; m_data = '0;
    end else if (flush || (bubble && !hold)) begin
      m_valid = 1'b0; m_ctrl = m_ctrl & ~KMASK;
    end else if (!hold) begin
      m_valid = in_valid;
      m_data  = in_data;
      m_ctrl  = in_valid ? in_ctrl : (in_ctrl & ~KMASK);
    end
    if (reset || stat_clr) begin
      m_stall = 0; m_bubble = 0; m_flush = 0;
    end else if (flush) begin
      if (m_flush < CMAX) m_flush++;
    end else if (hold) begin
      if (m_stall < CMAX) m_stall++;
    end else if (bubble) begin
      if (m_bubble < CMAX) m_bubble++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_valid", 64'(out_valid), 64'(m_valid));
      chk("model_ctrl",  64'(out_ctrl),  64'(m_ctrl));
      chk("model_data",  64'(out_data),  64'(m_data));
      if (!out_valid) chk("nop_masked", 64'(out_ctrl & KMASK), 64'd0);
`ifdef PIPE_STAT_EN
      chk("model_stall",  64'(stall_cnt),  64'(m_stall));
      chk("model_bubble", 64'(bubble_cnt), 64'(m_bubble));
      chk("model_flush",  64'(flush_cnt),  64'(m_flush));
`endif
    end
  end

  task automatic drive(input logic r, input logic h, input logic b, input logic f,
                       input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    reset = r; hold = h; bubble = b; flush = f; in_valid = v; in_ctrl = c; in_data = d;
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic v, input logic [CW-1:0] c,
                            input logic [DW-1:0] d);
    chk({name, "_valid"}, 64'(out_valid), 64'(v));
    chk({name, "_ctrl"},  64'(out_ctrl),  64'(c));
    chk({name, "_data"},  64'(out_data),  64'(d));
  endtask

  initial begin
    logic [CNTW-1:0] s0, b0, f0;
    @(negedge clk);
    drive(1, 0, 0, 0, 1, 8'hFF, 32'hDEADBEEF);
    chk_en = 1'b1;
    drive(1, 0, 0, 0, 1, 8'hFF, 32'hDEADBEEF);
    expect_out("reset", 1'b0, 8'h00, 32'h0);
    drive(0, 0, 0, 0, 1, 8'hFF, 32'hDEADBEEF);
    expect_out("first_load", 1'b1, 8'hFF, 32'hDEADBEEF);

    drive(0, 0, 0, 0, 1, 8'hA5, 32'h1234);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 1, 8'h5A, 32'h9999);
      expect_out("hold", 1'b1, 8'hA5, 32'h1234);
    end
    drive(0, 0, 0, 0, 1, 8'h5A, 32'h9999);
    expect_out("hold_release", 1'b1, 8'h5A, 32'h9999);

    drive(0, 0, 0, 0, 1, 8'hA5, 32'h1234);
    drive(0, 0, 1, 0, 1, 8'h77, 32'h5555);
    expect_out("bubble", 1'b0, 8'hA0, 32'h1234);

    drive(0, 0, 0, 0, 1, 8'hFF, 32'h4321);
    s0 = stall_cnt; b0 = bubble_cnt; f0 = flush_cnt;
    drive(0, 1, 1, 1, 1, 8'h11, 32'h2222);
    expect_out("flush_all", 1'b0, 8'hF0, 32'h4321);
`ifdef PIPE_STAT_EN
    chk("flush_all_fcnt", 64'(flush_cnt),  64'(f0 + 2'd1));
    chk("flush_all_scnt", 64'(stall_cnt),  64'(s0));
    chk("flush_all_bcnt", 64'(bubble_cnt), 64'(b0));
`endif

    drive(0, 0, 0, 0, 0, 8'h3C, 32'hABCD);
    expect_out("invalid_load", 1'b0, 8'h30, 32'hABCD);

`ifdef PIPE_STAT_EN
    stat_clr = 1'b1;
    drive(0, 0, 0, 0, 1, 8'h01, 32'h1);
    stat_clr = 1'b0;
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 1, 8'h02, 32'h2);
    chk("stall_sat", 64'(stall_cnt), 64'd3);
    stat_clr = 1'b1;
    drive(0, 1, 0, 1, 1, 8'h03, 32'h3);
    stat_clr = 1'b0;
    chk("clr_stall",  64'(stall_cnt),  64'd0);
    chk("clr_bubble", 64'(bubble_cnt), 64'd0);
    chk("clr_flush",  64'(flush_cnt),  64'd0);
`endif

    drive(0, 0, 0, 0, 1, 8'hC3, 32'h600D);
    drive(1, 1, 0, 0, 1, 8'h99, 32'h7777);
    expect_out("reset_mid_hold", 1'b0, 8'h00, 32'h0);
    drive(0, 0, 0, 0, 0, 8'hFF, 32'h8888);
    expect_out("after_reset_invalid", 1'b0, 8'hF0, 32'h8888);

    for (int i = 0; i < 3000; i++) begin
      stat_clr = ($urandom_range(0, 99) < 3);
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 70, CW'($urandom), $urandom);
    end
    stat_clr = 1'b0;
    drive(0, 0, 0, 0, 1, 8'h00, 32'h0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
